// File: rtl/y_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y_frame_reader_pkg
//  Description : Shared frame geometry defaults, reader states and the
//                sideband bundle carried alongside each memory read.
//  Revision    : 1.0 - initial release
// ============================================================================
package y_frame_reader_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_V_ACTIVE = 480;
    localparam int c_H_BLANK  = 16;
    localparam int c_ADDR_W   = 19;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic frame_start;
        logic line_end;
        logic last;
    } sideband_t;

endpackage
`default_nettype wire

// File: rtl/y_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : y_frame_reader_if
//  Description : Control handshake, frame-memory read port and Y pixel stream
//                of the frame reader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface y_frame_reader_if
    import y_frame_reader_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) ();

    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              pixel_valid_out;
    logic [7:0]        y_out;
    logic              frame_start;
    logic              line_end;

    modport master (
        input  start, hold, mem_rdata,
        output busy, done, mem_rd_en, mem_addr,
               pixel_valid_out, y_out, frame_start, line_end
    );

    modport slave (
        output start, hold, mem_rdata,
        input  busy, done, mem_rd_en, mem_addr,
               pixel_valid_out, y_out, frame_start, line_end
    );

endinterface
`default_nettype wire

// File: rtl/y_frame_reader_pix_sideband_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pix_sideband_pipe
//  Description : Two-stage delay that keeps pixel flags aligned with the
//                memory read latency plus the output data register.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_sideband_pipe
    import y_frame_reader_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire sideband_t i_sb,
    output logic           o_s1_valid,
    output sideband_t      o_sb
);

    sideband_t r_s1;
    sideband_t r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_sb;
            r_s2 <= r_s1;
        end
    end

    assign o_s1_valid = r_s1.valid;
    assign o_sb       = r_s2;

endmodule
`default_nettype wire

// File: rtl/y_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : y_frame_reader
//  Description : Raster reader streaming an 8-bit Y frame out of a
//                synchronous-read memory with per-line horizontal blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module y_frame_reader
    import y_frame_reader_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int H_BLANK  = c_H_BLANK,
    parameter int ADDR_W   = c_ADDR_W
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    y_frame_reader_if.master bus
);

    localparam int c_X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int c_Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int c_B_W = (H_BLANK  > 1) ? $clog2(H_BLANK)  : 1;

    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(H_ACTIVE - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(V_ACTIVE - 1);
    localparam logic [c_B_W-1:0] c_B_LAST = c_B_W'(H_BLANK - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [c_X_W-1:0]  r_x;
    logic [c_Y_W-1:0]  r_y;
    logic [c_B_W-1:0]  r_blank;
    logic [7:0]        r_y_out;

    logic      w_issue;
    logic      w_x_last;
    logic      w_y_last;
    logic      w_blank_last;
    logic      w_s1_valid;
    logic      w_done;
    sideband_t w_sb_in;
    sideband_t w_sb_out;

    assign w_issue      = (r_state == ST_ACTIVE) && !bus.hold;
    assign w_x_last     = (r_x == c_X_LAST);
    assign w_y_last     = (r_y == c_Y_LAST);
    assign w_blank_last = (r_blank == c_B_LAST);
    assign w_done       = w_sb_out.valid && w_sb_out.last;

    // Flags are decided at issue time so they stay paired with their read.
    assign w_sb_in.valid       = w_issue;
    assign w_sb_in.frame_start = w_issue && (r_addr == '0);
    assign w_sb_in.line_end    = w_issue && w_x_last;
    assign w_sb_in.last        = w_issue && w_x_last && w_y_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_issue && w_x_last) w_state_nxt = w_y_last ? ST_DRAIN : ST_HBLANK;
            ST_HBLANK: if (w_blank_last) w_state_nxt = ST_ACTIVE;
            ST_DRAIN:  if (w_done) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // r_blank rests at zero outside HBLANK, so entry needs no explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_blank <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.start) begin
                r_addr  <= '0;
                r_x     <= '0;
                r_y     <= '0;
                r_blank <= '0;
            end
            if (w_issue) begin
                r_addr <= r_addr + 1'b1;
                if (w_x_last) begin
                    r_x <= '0;
                    if (!w_y_last) r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            if (r_state == ST_HBLANK) begin
                r_blank <= w_blank_last ? '0 : r_blank + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_out <= 8'd0;
        end else begin
            r_y_out <= w_s1_valid ? bus.mem_rdata : 8'd0;
        end
    end

    pix_sideband_pipe u_sideband (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sb       (w_sb_in),
        .o_s1_valid (w_s1_valid),
        .o_sb       (w_sb_out)
    );

    assign bus.mem_rd_en       = w_issue;
    assign bus.mem_addr        = r_addr;
    assign bus.pixel_valid_out = w_sb_out.valid;
    assign bus.y_out           = r_y_out;
    assign bus.frame_start     = w_sb_out.frame_start;
    assign bus.line_end        = w_sb_out.line_end;
    assign bus.done            = w_done;
    assign bus.busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_y_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y_frame_reader
//  Description : Self-checking bench for y_frame_reader against a pixel-index
//                reference model, plus a larger-geometry count check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y_frame_reader;
    import y_frame_reader_pkg::*;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int B   = 2;
    localparam int AW  = 4;
    localparam int N   = H * V;
    localparam int H2  = 40;
    localparam int V2  = 30;
    localparam int B2  = 3;
    localparam int AW2 = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    y_frame_reader_if #(.ADDR_W(AW))  bus  ();
    y_frame_reader_if #(.ADDR_W(AW2)) bus2 ();

    y_frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(B), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    y_frame_reader #(.H_ACTIVE(H2), .V_ACTIVE(V2), .H_BLANK(B2), .ADDR_W(AW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    // Frame memory content is the low byte of the address.
    always @(posedge clk) if (bus.mem_rd_en)  bus.mem_rdata  <= 8'(bus.mem_addr);
    always @(posedge clk) if (bus2.mem_rd_en) bus2.mem_rdata <= 8'(bus2.mem_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel index of the next read, remaining blank cycles,
    // and the pixel index sitting in each latency stage (-1 = none).
    bit m_busy;
    int m_next, m_blank, m_stage, m_out;

    task automatic m_reset();
        m_busy = 0; m_next = 0; m_blank = 0; m_stage = -1; m_out = -1;
    endtask

    int cyc;
    int o_nvalid, o_ndone, o_nle, o_nfs, o_first_rd, o_first_val, o_done_pix;
    int o_t [0:63];
    int o_v [0:63];

    task automatic obs_clear();
        cyc = 0; o_nvalid = 0; o_ndone = 0; o_nle = 0; o_nfs = 0;
        o_first_rd = -1; o_first_val = -1; o_done_pix = -1;
        for (int i = 0; i < 64; i++) begin o_t[i] = 0; o_v[i] = 0; end
    endtask

    task automatic cycle(input bit st, input bit hd);
        bit e_rd;
        bit done_now;
        @(negedge clk);
        bus.start = st;
        bus.hold  = hd;
        #1;
        e_rd = m_busy && (m_blank == 0) && (m_next < N) && !hd;
        chk("mem_rd_en",   bus.mem_rd_en,       e_rd);
        chk("mem_addr",    bus.mem_addr,        m_next % (1 << AW));
        chk("pixel_valid", bus.pixel_valid_out, m_out >= 0);
        chk("y_out",       bus.y_out,           (m_out >= 0) ? m_out % 256 : 0);
        chk("frame_start", bus.frame_start,     m_out == 0);
        chk("line_end",    bus.line_end,        (m_out >= 0) && (m_out % H == H - 1));
        chk("done",        bus.done,            m_out == N - 1);
        chk("busy",        bus.busy,            m_busy);

        if (bus.mem_rd_en && o_first_rd < 0) o_first_rd = cyc;
        if (bus.pixel_valid_out) begin
            if (o_first_val < 0) o_first_val = cyc;
            if (o_nvalid < 64) begin o_t[o_nvalid] = cyc; o_v[o_nvalid] = int'(bus.y_out); end
            o_nvalid++;
        end
        if (bus.line_end)    o_nle++;
        if (bus.frame_start) o_nfs++;
        if (bus.done) begin o_ndone++; o_done_pix = int'(bus.y_out); end
        cyc++;

        done_now = (m_out == N - 1);
        m_out    = m_stage;
        m_stage  = e_rd ? m_next : -1;
        if (!m_busy) begin
            if (st) begin m_busy = 1; m_next = 0; m_blank = 0; end
        end else if (e_rd) begin
            if ((m_next % H == H - 1) && (m_next != N - 1)) m_blank = B;
            m_next++;
        end else if (m_blank > 0) begin
            m_blank--;
        end else if (done_now) begin
            m_busy = 0;
        end
    endtask

    // mode 0 plain, 1 hold at x=2 of line 1, 2 hold over blank+1,
    // 3 extra starts mid-frame and in the done cycle, 4 random
    task automatic frame(input int mode, input int ncyc);
        int hcnt;
        bit st, hd;
        hcnt = 0;
        obs_clear();
        for (int i = 0; i < ncyc; i++) begin
            st = (i == 0);
            hd = 1'b0;
            case (mode)
                1: if (m_busy && m_next == 6 && m_blank == 0 && hcnt < 3) begin hd = 1'b1; hcnt++; end
                2: if (m_busy && m_next == 4) begin
                       if (m_blank > 0) hd = 1'b1;
                       else if (hcnt < 1) begin hd = 1'b1; hcnt++; end
                   end
                3: st = (i == 0) || (i == 10) || (m_busy && m_out == N - 1);
                4: begin st = ($urandom_range(7) == 0); hd = ($urandom_range(2) == 0); end
                default: ;
            endcase
            cycle(st, hd);
        end
    endtask

    int b_nvalid = 0, b_nle = 0, b_ndone = 0, b_last_addr = -1;
    always @(negedge clk) begin
        if (bus2.pixel_valid_out) b_nvalid++;
        if (bus2.line_end)        b_nle++;
        if (bus2.done)            b_ndone++;
        if (bus2.mem_rd_en)       b_last_addr = int'(bus2.mem_addr);
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, bus.mem_rd_en,       0);
        chk({tag, "_addr"},  bus.mem_addr,        0);
        chk({tag, "_valid"}, bus.pixel_valid_out, 0);
        chk({tag, "_y"},     bus.y_out,           0);
        chk({tag, "_fs"},    bus.frame_start,     0);
        chk({tag, "_le"},    bus.line_end,        0);
        chk({tag, "_busy"},  bus.busy,            0);
        chk({tag, "_done"},  bus.done,            0);
    endtask

    initial begin
        bus.start = 1'b0; bus.hold = 1'b0;
        bus2.start = 1'b0; bus2.hold = 1'b0;
        m_reset();
        obs_clear();
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        frame(0, 30);
        chk("plain_count", o_nvalid, 12);
        for (int k = 0; k < 12; k++) chk("plain_pix_order", o_v[k], k);
        chk("plain_line0_contiguous", o_t[3] - o_t[0], 3);
        chk("plain_gap_after_px3", o_t[4] - o_t[3] - 1, 2);
        chk("plain_gap_after_px7", o_t[8] - o_t[7] - 1, 2);
        chk("plain_first_rd_cycle", o_first_rd, 1);
        chk("plain_latency", o_first_val - o_first_rd, 2);
        chk("plain_frame_start_count", o_nfs, 1);
        chk("plain_line_end_count", o_nle, 3);
        chk("plain_done_count", o_ndone, 1);
        chk("plain_done_pixel", o_done_pix, 11);

        frame(1, 30);
        chk("hold_count", o_nvalid, 12);
        chk("hold_gap_px5_px6", o_t[6] - o_t[5] - 1, 3);

        frame(2, 30);
        chk("blankhold_gap", o_t[4] - o_t[3] - 1, B + 1);
        chk("blankhold_px4", o_v[4], 4);
        chk("blankhold_count", o_nvalid, 12);

        frame(3, 40);
        chk("restart_done_count", o_ndone, 1);
        chk("restart_count", o_nvalid, 12);

        // Reset in the cycle where pixel 6 would be presented
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 40 && m_out != 6; i++) cycle(1'b0, 1'b0);
        chk("reach_px6", m_out, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        frame(0, 30);
        chk("after_reset_count", o_nvalid, 12);
        chk("after_reset_px0", o_v[0], 0);
        chk("after_reset_px11", o_v[11], 11);
        chk("after_reset_done_count", o_ndone, 1);

        @(negedge clk) bus2.start = 1'b1;
        @(negedge clk) bus2.start = 1'b0;
        for (int i = 0; i < 1400; i++) cycle(1'b0, 1'b0);
        chk("big_valid_count", b_nvalid, H2 * V2);
        chk("big_line_end_count", b_nle, V2);
        chk("big_done_count", b_ndone, 1);
        chk("big_last_addr", b_last_addr, H2 * V2 - 1);
        chk("big_busy_after", bus2.busy, 0);

        frame(4, 800);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
        chk("random_final_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y_frame_reader.md
# y_frame_reader

Raster pixel-stream source that reads an 8-bit Y frame from a synchronous-read memory. It emits the frame as a `pixel_valid_out`/`y_out` stream of `H_ACTIVE`×`V_ACTIVE` pixels, with horizontal blanking after each line. It is the producer that drives the Y-channel enhancement and equalisation pipeline (same valid/data convention, same line length). A `start`/`busy`/`done` handshake controls it from the frame controller, and a `hold` input stalls pixel issue.

## Interface
- `H_ACTIVE`, 640, pixels per line
- `V_ACTIVE`, 480, lines per frame
- `H_BLANK`, 16, idle cycles between lines; must be ≥1
- `ADDR_W`, 19, memory address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin frame; sampled only in IDLE
- `hold`  in  1  stall; no read is issued in a cycle where `hold`=1
- `mem_rd_en`  out  1  read strobe to frame memory
- `mem_addr`  out  ADDR_W  linear address, y·H_ACTIVE+x
- `mem_rdata`  in  8  read data, valid the cycle after `mem_rd_en`
- `pixel_valid_out`  out  1  pixel qualifier
- `y_out`  out  8  pixel value; 0 when `pixel_valid_out`=0
- `frame_start`  out  1  high with pixel (0,0)
- `line_end`  out  1  high with each pixel x=H_ACTIVE−1
- `busy`  out  1  high from the cycle after `start` is accepted until after `done`
- `done`  out  1  one-cycle pulse, coincident with the last pixel

## Operation
- States: IDLE, ACTIVE, HBLANK, DRAIN.
  - IDLE: if `start`=1 → ACTIVE; the address counter, x counter and y counter are cleared to 0.
  - ACTIVE: `mem_rd_en` = (state==ACTIVE)&&!`hold`, combinational. On each issued read, `mem_addr` and x increment.
    - Read at x=H_ACTIVE−1 with y<V_ACTIVE−1: x←0, y+1, → HBLANK.
    - Read at x=H_ACTIVE−1 with y=V_ACTIVE−1: → DRAIN.
  - HBLANK: counts H_BLANK cycles, ignoring `hold`, then → ACTIVE. If `hold` is still high on entry to ACTIVE, ACTIVE waits.
  - DRAIN: waits for the final read to reach the output, pulses `done` with the last pixel, then → IDLE.
- `start` outside IDLE is ignored, including in the `done` cycle.
- `mem_addr` is a registered counter. It is not multiplied from x/y. It holds its value while `hold` is high or while blanking.
- Each issued read produces exactly one output pixel. There are no drops or duplicates under any `hold` pattern.
- Sideband flags are computed at issue time and travel with the read: `frame_start` when addr==0, `line_end` when x==H_ACTIVE−1, and last when y==V_ACTIVE−1 and x==H_ACTIVE−1.
- Reset, including mid-frame: all state is cleared immediately → IDLE; every output is 0 and in-flight reads are discarded. After reset, the next `start` restarts at address 0.

## Timing
- `start` is sampled at edge E0. `busy`=1 and the first `mem_rd_en` (addr 0, if `hold`=0) occur in the cycle after E0.
- A read in cycle k delivers `mem_rdata` in k+1. That value is registered, so `pixel_valid_out`/`y_out` are high in cycle k+2. Fixed latency is 2 cycles and the sideband flags have the same latency.
- With `hold`=0 throughout, the output is H_ACTIVE consecutive valid cycles per line, then exactly H_BLANK invalid cycles.
- A `hold` high for n cycles during ACTIVE produces an n-cycle valid gap two cycles later.
- `done` is asserted in the same cycle as the last `pixel_valid_out` and `line_end`. `busy` is 0 from the following cycle.
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `pixel_valid_out`=0, `y_out`=0, `frame_start`=0, `line_end`=0, `busy`=0, `done`=0.

## Structure
- Shared package: default H_ACTIVE, V_ACTIVE, H_BLANK, ADDR_W constants and the state enum (IDLE/ACTIVE/HBLANK/DRAIN). The downstream Y blocks use the same H_ACTIVE.
- One sub-module, `pix_sideband_pipe`: a 2-stage register delay carrying valid, frame_start, line_end and last, with asynchronous reset to 0.
- The FSM, counters and data capture live in the top level.

## Test plan
- Set H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, with memory data = addr[7:0]; pulse `start`.
  - Required: pixels 0..11 in order; exactly 2 invalid cycles after pixels 3 and 7.
  - Required: `frame_start` with pixel 0; `line_end` with pixels 3, 7 and 11; `done` with pixel 11 only.
  - Required: first valid 2 cycles after the first `mem_rd_en`.
- Same config, `hold`=1 for 3 cycles while x=2 of line 1. Required: a 3-cycle valid gap between pixels 5 and 6; 12 pixels total.
- Same config, `hold` high throughout HBLANK plus 1 cycle. Required: the blank length is H_BLANK+1, and the first pixel of the next line is intact.
- Same config, `start` pulsed mid-frame and again in the `done` cycle. Required: both are ignored; exactly one frame and one `done`.
- Same config, assert `rst_n`=0 at pixel 6. Required: all outputs are 0 immediately. A new `start` yields pixels 0..11 from addr 0.
- Default parameters, `hold`=0. Required: 307200 valid pixels, last `mem_addr`=307199, 480 `line_end` pulses and 1 `done`.
